// File: rtl/uart_pkg.sv
// Shared register layouts, address map and interrupt identification codes
// for the 16550-style UART register block.
package uart_pkg;

  localparam logic [2:0] ADDR_RBR_THR = 3'd0;
  localparam logic [2:0] ADDR_IER     = 3'd1;
  localparam logic [2:0] ADDR_IIR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR     = 3'd3;
  localparam logic [2:0] ADDR_MCR     = 3'd4;
  localparam logic [2:0] ADDR_LSR     = 3'd5;
  localparam logic [2:0] ADDR_MSR     = 3'd6;
  localparam logic [2:0] ADDR_SCR     = 3'd7;
  localparam logic [2:0] ADDR_DLL     = 3'd0;
  localparam logic [2:0] ADDR_DLM     = 3'd1;

  localparam logic [3:0] IIR_RLS  = 4'h6;
  localparam logic [3:0] IIR_RDA  = 4'h4;
  localparam logic [3:0] IIR_CTO  = 4'hC;
  localparam logic [3:0] IIR_THRE = 4'h2;
  localparam logic [3:0] IIR_MSR  = 4'h0;
  localparam logic [3:0] IIR_NONE = 4'h1;

  typedef struct packed {
    logic       dlab;
    logic       brk;
    logic       stick;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } lcr_t;

  typedef struct packed {
    logic [1:0] trig;
    logic [1:0] rsvd;
    logic       dma;
    logic       txr;
    logic       rxr;
    logic       en;
  } fcr_t;

  typedef struct packed {
    logic err;
    logic temt;
    logic thre;
    logic bi;
    logic fe;
    logic pe;
    logic oe;
    logic dr;
  } lsr_t;

  typedef struct packed {
    logic edssi;
    logic elsi;
    logic etbei;
    logic erbfi;
  } ier_t;

  typedef struct packed {
    logic dcd;
    logic ri;
    logic dsr;
    logic cts;
    logic ddcd;
    logic teri;
    logic ddsr;
    logic dcts;
  } msr_t;

  // RX trigger level scaled to the FIFO depth; 0 while the FIFO is disabled.
  function automatic int rx_trigger_level(input fcr_t f, input int depth);
    if (!f.en) return 0;
    case (f.trig)
      2'b00:   return 1;
      2'b01:   return depth / 4;
      2'b10:   return depth / 2;
      default: return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/uart_regs_irq_if.sv
// CPU-side register bus of the UART: single-cycle strobes, 3-bit address,
// registered read data.
interface uart_regs_irq_if;
  logic       wr_i;
  logic       rd_i;
  logic [2:0] addr_i;
  logic [7:0] din_i;
  logic [7:0] dout_o;

  modport master (output wr_i, rd_i, addr_i, din_i, input dout_o);
  modport slave  (input wr_i, rd_i, addr_i, din_i, output dout_o);
endinterface

// File: rtl/uart_baud_gen.sv
// Divisor latch and baud down-counter; emits a one-cycle tick every DL+1
// clocks, none while DL is zero.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dll_we,
  input  logic             dlm_we,
  input  logic [7:0]       din,
  output logic [DIV_W-1:0] dl,
  output logic             baud_out
);

  logic [DIV_W-1:0] dl_reg;
  logic [DIV_W-1:0] dl_next;
  logic [DIV_W-1:0] cnt_reg;
  logic             dl_we;

  assign dl_we = dll_we | dlm_we;
  assign dl    = dl_reg;

  always_comb begin
    dl_next = dl_reg;
    if (dll_we) dl_next[7:0] = din;
    if (dlm_we) dl_next[DIV_W-1:8] = din[DIV_W-9:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dl_reg   <= '0;
      cnt_reg  <= '0;
      baud_out <= 1'b0;
    end else begin
      dl_reg <= dl_next;
      // A divisor write restarts the period from the new value.
      if (dl_we)
        cnt_reg <= dl_next;
      else if (cnt_reg == '0)
        cnt_reg <= dl_reg;
      else
        cnt_reg <= cnt_reg - DIV_W'(1);
      baud_out <= (cnt_reg == '0) && (dl_reg != '0) && !dl_we;
    end
  end

endmodule

// File: rtl/uart_regs_irq.sv
// 16550-style register file: address decode, FIFO strobes, sticky line
// status, modem status deltas, RX character timeout and prioritised IIR/irq.
module uart_regs_irq
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int DIV_W         = 16,
  parameter int TIMEOUT_TICKS = 640,
  parameter int CW            = $clog2(FIFO_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  uart_regs_irq_if.slave  bus,
  output logic            tx_push_o,
  output logic            rx_pop_o,
  input  logic [7:0]      rx_fifo_in,
  input  logic [CW-1:0]   rx_fifo_count_i,
  input  logic            rx_push_i,
  input  logic            tx_fifo_empty_i,
  input  logic            tx_shift_empty_i,
  input  logic            rx_oe,
  input  logic            rx_pe,
  input  logic            rx_fe,
  input  logic            rx_bi,
  input  logic            cts_n_i,
  input  logic            dsr_n_i,
  input  logic            dcd_n_i,
  input  logic            ri_n_i,
  output logic            baud_out,
  output logic            tx_rst,
  output logic            rx_rst,
  output logic [CW-1:0]   rx_fifo_threshold,
  output logic [7:0]      lcr_o,
  output logic [4:0]      mcr_o,
  output logic            irq_o
);

  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  lcr_t             lcr_reg;
  ier_t             ier_reg;
  fcr_t             fcr_reg;
  logic [4:0]       mcr_reg;
  logic [7:0]       scr_reg;
  logic [3:0]       err_reg;         // {bi, fe, pe, oe}
  logic [TO_W-1:0]  to_cnt_reg;
  logic             to_pend_reg;
  logic             thre_pend_reg;
  logic             tx_empty_prev_reg;
  logic [3:0]       modem_prev_reg;  // {dcd, ri, dsr, cts}
  logic [3:0]       delta_reg;       // {ddcd, teri, ddsr, dcts}

  logic [DIV_W-1:0] dl;
  logic             dlab;
  logic             rx_nonempty;
  logic             rda;
  logic             wr_thr, wr_ier, wr_dll, wr_dlm, wr_fcr, wr_lcr, wr_mcr, wr_scr;
  logic             rd_iir, rd_lsr, rd_msr;
  logic [3:0]       err_evt;
  logic [3:0]       modem_now;
  logic [3:0]       delta_evt;
  logic [3:0]       iir_id;
  logic [7:0]       iir;
  logic [7:0]       rd_data;
  lsr_t             lsr;
  msr_t             msr;

  assign dlab   = lcr_reg.dlab;
  assign wr_thr = bus.wr_i && bus.addr_i == ADDR_RBR_THR && !dlab;
  assign wr_ier = bus.wr_i && bus.addr_i == ADDR_IER && !dlab;
  assign wr_dll = bus.wr_i && bus.addr_i == ADDR_DLL && dlab;
  assign wr_dlm = bus.wr_i && bus.addr_i == ADDR_DLM && dlab;
  assign wr_fcr = bus.wr_i && bus.addr_i == ADDR_IIR_FCR;
  assign wr_lcr = bus.wr_i && bus.addr_i == ADDR_LCR;
  assign wr_mcr = bus.wr_i && bus.addr_i == ADDR_MCR;
  assign wr_scr = bus.wr_i && bus.addr_i == ADDR_SCR;
  assign rd_iir = bus.rd_i && bus.addr_i == ADDR_IIR_FCR;
  assign rd_lsr = bus.rd_i && bus.addr_i == ADDR_LSR;
  assign rd_msr = bus.rd_i && bus.addr_i == ADDR_MSR;

  assign tx_push_o = wr_thr;
  assign rx_pop_o  = bus.rd_i && bus.addr_i == ADDR_RBR_THR && !dlab;

  assign lcr_o             = lcr_reg;
  assign mcr_o             = mcr_reg;
  assign rx_fifo_threshold = CW'(rx_trigger_level(fcr_reg, FIFO_DEPTH));
  assign rx_nonempty       = rx_fifo_count_i != '0;
  assign rda               = rx_nonempty && (rx_fifo_count_i >= rx_fifo_threshold);
  assign err_evt           = {rx_bi, rx_fe, rx_pe, rx_oe};

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .dll_we   (wr_dll),
    .dlm_we   (wr_dlm),
    .din      (bus.din_i),
    .dl       (dl),
    .baud_out (baud_out)
  );

  // Loopback routes RTS/DTR/OUT1/OUT2 onto CTS/DSR/RI/DCD.
  always_comb begin
    if (mcr_reg[4])
      modem_now = {mcr_reg[3], mcr_reg[2], mcr_reg[0], mcr_reg[1]};
    else
      modem_now = {~dcd_n_i, ~ri_n_i, ~dsr_n_i, ~cts_n_i};
  end

  assign delta_evt = {modem_now[3] ^ modem_prev_reg[3],
                      modem_prev_reg[2] & ~modem_now[2],
                      modem_now[1] ^ modem_prev_reg[1],
                      modem_now[0] ^ modem_prev_reg[0]};
  assign msr = msr_t'({modem_now, delta_reg});

  always_comb begin
    lsr      = '0;
    lsr.dr   = rx_nonempty;
    lsr.oe   = err_reg[0];
    lsr.pe   = err_reg[1];
    lsr.fe   = err_reg[2];
    lsr.bi   = err_reg[3];
    lsr.thre = tx_fifo_empty_i;
    lsr.temt = tx_fifo_empty_i & tx_shift_empty_i;
    lsr.err  = |err_reg[3:1];
  end

  always_comb begin
    iir_id = IIR_NONE;
    if (ier_reg.elsi && |err_reg)
      iir_id = IIR_RLS;
    else if (ier_reg.erbfi && rda)
      iir_id = IIR_RDA;
    else if (ier_reg.erbfi && to_pend_reg)
      iir_id = IIR_CTO;
    else if (ier_reg.etbei && thre_pend_reg)
      iir_id = IIR_THRE;
    else if (ier_reg.edssi && |delta_reg)
      iir_id = IIR_MSR;
    iir = {{2{fcr_reg.en}}, 2'b00, iir_id};
  end

  always_comb begin
    rd_data = '0;
    case (bus.addr_i)
      ADDR_RBR_THR: rd_data = dlab ? dl[7:0] : rx_fifo_in;
      ADDR_IER:     rd_data = dlab ? 8'(dl >> 8) : {4'b0000, ier_reg};
      ADDR_IIR_FCR: rd_data = iir;
      ADDR_LCR:     rd_data = lcr_reg;
      ADDR_MCR:     rd_data = {3'b000, mcr_reg};
      ADDR_LSR:     rd_data = lsr;
      ADDR_MSR:     rd_data = msr;
      default:      rd_data = scr_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lcr_reg           <= '0;
      ier_reg           <= '0;
      fcr_reg           <= '0;
      mcr_reg           <= '0;
      scr_reg           <= '0;
      err_reg           <= '0;
      to_cnt_reg        <= '0;
      to_pend_reg       <= 1'b0;
      thre_pend_reg     <= 1'b0;
      tx_empty_prev_reg <= 1'b1;
      modem_prev_reg    <= '0;
      delta_reg         <= '0;
      tx_rst            <= 1'b0;
      rx_rst            <= 1'b0;
      irq_o             <= 1'b0;
      bus.dout_o        <= '0;
    end else begin
      if (wr_ier) ier_reg <= ier_t'(bus.din_i[3:0]);
      if (wr_fcr) fcr_reg <= fcr_t'(bus.din_i & 8'hF9);
      if (wr_lcr) lcr_reg <= lcr_t'(bus.din_i);
      if (wr_mcr) mcr_reg <= bus.din_i[4:0];
      if (wr_scr) scr_reg <= bus.din_i;
      rx_rst <= wr_fcr && bus.din_i[1];
      tx_rst <= wr_fcr && bus.din_i[2];

      // Read-to-clear status: an event in the read cycle survives the clear.
      err_reg        <= (rd_lsr ? 4'b0000 : err_reg) | err_evt;
      delta_reg      <= (rd_msr ? 4'b0000 : delta_reg) | delta_evt;
      modem_prev_reg <= modem_now;

      tx_empty_prev_reg <= tx_fifo_empty_i;
      if ((tx_fifo_empty_i && !tx_empty_prev_reg) ||
          (wr_ier && bus.din_i[1] && !ier_reg.etbei && tx_fifo_empty_i))
        thre_pend_reg <= 1'b1;
      else if (wr_thr || (rd_iir && iir_id == IIR_THRE))
        thre_pend_reg <= 1'b0;

      if (rx_push_i || rx_pop_o || !rx_nonempty || !fcr_reg.en)
        to_cnt_reg <= '0;
      else if (baud_out && to_cnt_reg != TO_W'(TIMEOUT_TICKS))
        to_cnt_reg <= to_cnt_reg + TO_W'(1);

      if (rx_push_i || rx_pop_o || !rx_nonempty)
        to_pend_reg <= 1'b0;
      else if (to_cnt_reg == TO_W'(TIMEOUT_TICKS))
        to_pend_reg <= 1'b1;

      irq_o <= !iir[0];
      if (bus.rd_i) bus.dout_o <= rd_data;
    end
  end

endmodule
